// File: rtl/cpu_mem_arbiter_pkg.sv
// Shared state/owner encodings and counter sizing for the CPU memory-port arbiter.
// Imported by the arbiter top and its pick sub-module.
package cpu_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_REQ  = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } arb_owner_e;

    // Wide enough for the largest supported MAX_WAIT (15).
    localparam int STARVE_W = 4;

    function automatic logic [STARVE_W-1:0] starve_sat_inc(
        input logic [STARVE_W-1:0] cnt,
        input logic [STARVE_W-1:0] limit
    );
        return (cnt >= limit) ? limit : cnt + STARVE_W'(1);
    endfunction

endpackage

// File: rtl/cpu_mem_arbiter_if.sv
// Bundle of fetch, data and downstream memory signals around the arbiter.
// slave = arbiter view; master = CPU wrapper plus memory environment view.
interface cpu_mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic              i_req;
    logic [AW-1:0]     i_addr;
    logic              i_gnt;
    logic              i_rvalid;

    logic              d_req;
    logic [AW-1:0]     d_addr;
    logic [DW-1:0]     d_wdata;
    logic [DW/8-1:0]   d_wstrb;
    logic              d_gnt;
    logic              d_rvalid;

    logic [DW-1:0]     rdata;

    logic              m_req;
    logic [AW-1:0]     m_addr;
    logic [DW-1:0]     m_wdata;
    logic [DW/8-1:0]   m_wstrb;
    logic              m_gnt;
    logic              m_rvalid;
    logic [DW-1:0]     m_rdata;

    modport slave (
        input  i_req, i_addr, d_req, d_addr, d_wdata, d_wstrb,
        input  m_gnt, m_rvalid, m_rdata,
        output i_gnt, i_rvalid, d_gnt, d_rvalid, rdata,
        output m_req, m_addr, m_wdata, m_wstrb
    );

    modport master (
        output i_req, i_addr, d_req, d_addr, d_wdata, d_wstrb,
        output m_gnt, m_rvalid, m_rdata,
        input  i_gnt, i_rvalid, d_gnt, d_rvalid, rdata,
        input  m_req, m_addr, m_wdata, m_wstrb
    );

endinterface

// File: rtl/cpu_mem_arbiter_pick.sv
// Data-first priority pick with a saturating starvation counter that
// forces an instruction fetch after MAX_WAIT data grants taken while fetch waits.
module cpu_mem_arb_pick
    import cpu_mem_arbiter_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_req,
    input  logic d_req,
    input  logic grant_fire,
    input  logic grant_is_d,
    output logic pick_i,
    output logic pick_d
);

    localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(MAX_WAIT);

    logic [STARVE_W-1:0] r_starve_cnt;
    logic                w_starved;

    assign w_starved = i_req && (r_starve_cnt == LIMIT);
    assign pick_d    = d_req && !w_starved;
    assign pick_i    = i_req && !pick_d;

    // The counter only measures data grants that overtook a waiting fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve_cnt <= '0;
        end else if (!i_req) begin
            r_starve_cnt <= '0;
        end else if (grant_fire) begin
            if (grant_is_d) begin
                r_starve_cnt <= starve_sat_inc(r_starve_cnt, LIMIT);
            end else begin
                r_starve_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/cpu_mem_arbiter.sv
// Shares one memory port between instruction fetch and data access, one access
// outstanding at a time, routing each response back to the requester that issued it.
module cpu_mem_arbiter
    import cpu_mem_arbiter_pkg::*;
#(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    cpu_mem_arbiter_if.slave  bus
);

    arb_state_e       r_state;
    arb_state_e       w_state_next;
    arb_owner_e       r_owner;
    logic [AW-1:0]    r_addr;
    logic [DW-1:0]    r_wdata;
    logic [DW/8-1:0]  r_wstrb;

    logic w_pick_i;
    logic w_pick_d;
    logic w_pick_any;
    logic w_grant_fire;
    logic w_resp_fire;
    logic w_arb_point;

    assign w_grant_fire = (r_state == ARB_REQ)  && bus.m_gnt;
    assign w_resp_fire  = (r_state == ARB_RESP) && bus.m_rvalid;
    assign w_arb_point  = (r_state == ARB_IDLE) || w_resp_fire;
    assign w_pick_any   = w_pick_i || w_pick_d;

    cpu_mem_arb_pick #(
        .MAX_WAIT (MAX_WAIT)
    ) u_pick (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_req      (bus.i_req),
        .d_req      (bus.d_req),
        .grant_fire (w_grant_fire),
        .grant_is_d (r_owner == OWN_D),
        .pick_i     (w_pick_i),
        .pick_d     (w_pick_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        bus.m_req    = 1'b0;
        bus.i_gnt    = 1'b0;
        bus.d_gnt    = 1'b0;
        bus.i_rvalid = 1'b0;
        bus.d_rvalid = 1'b0;
        bus.rdata    = '0;
        unique case (r_state)
            ARB_IDLE: begin
                if (w_pick_any) begin
                    w_state_next = ARB_REQ;
                end
            end
            ARB_REQ: begin
                bus.m_req = 1'b1;
                bus.i_gnt = bus.m_gnt && (r_owner == OWN_I);
                bus.d_gnt = bus.m_gnt && (r_owner == OWN_D);
                if (bus.m_gnt) begin
                    w_state_next = ARB_RESP;
                end
            end
            ARB_RESP: begin
                bus.i_rvalid = bus.m_rvalid && (r_owner == OWN_I);
                bus.d_rvalid = bus.m_rvalid && (r_owner == OWN_D);
                // Completion doubles as the next arbitration point: no idle bubble.
                if (bus.m_rvalid) begin
                    w_state_next = w_pick_any ? ARB_REQ : ARB_IDLE;
                end
            end
            default: begin
                w_state_next = ARB_IDLE;
            end
        endcase
        if (bus.i_rvalid || bus.d_rvalid) begin
            bus.rdata = bus.m_rdata;
        end
    end

    // Payload is captured only at arbitration points so it stays stable through REQ.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner <= OWN_NONE;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wstrb <= '0;
        end else if (w_arb_point) begin
            if (w_pick_d) begin
                r_owner <= OWN_D;
                r_addr  <= bus.d_addr;
                r_wdata <= bus.d_wdata;
                r_wstrb <= bus.d_wstrb;
            end else if (w_pick_i) begin
                r_owner <= OWN_I;
                r_addr  <= bus.i_addr;
                r_wdata <= '0;
                r_wstrb <= '0;
            end else begin
                r_owner <= OWN_NONE;
            end
        end
    end

    assign bus.m_addr  = r_addr;
    assign bus.m_wdata = r_wdata;
    assign bus.m_wstrb = r_wstrb;

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Directed bench for cpu_mem_arbiter: fetch/data sequencing, priority, starvation,
// downstream stalls, reset abort and stray responses, with hand-computed expectations.
module tb_cpu_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    logic          gnt_en    = 1'b1;
    logic          auto_en   = 1'b1;
    logic          force_rv  = 1'b0;
    logic          r_auto_rv = 1'b0;
    logic [DW-1:0] resp_data = '0;

    cpu_mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    cpu_mem_arbiter #(
        .AW       (AW),
        .DW       (DW),
        .MAX_WAIT (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Memory model: zero-wait grant when enabled, response one cycle after grant.
    assign bus.m_gnt = bus.m_req & gnt_en;
    always @(posedge clk) r_auto_rv <= auto_en & bus.m_req & bus.m_gnt;
    assign bus.m_rvalid = r_auto_rv | force_rv;
    assign bus.m_rdata  = resp_data;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.i_req = 1'b0; bus.i_addr = '0;
        bus.d_req = 1'b0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_wstrb = '0;
        resp_data = 32'hFFFF_FFFF;
        #3;
        n_checks++;
        if ({bus.m_req, bus.i_gnt, bus.d_gnt, bus.i_rvalid, bus.d_rvalid} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 00000", {bus.m_req, bus.i_gnt, bus.d_gnt, bus.i_rvalid, bus.d_rvalid});
        end
        n_checks++;
        if ({bus.m_addr, bus.m_wdata, bus.m_wstrb} !== '0) begin
            n_fail++;
            $display("FAIL reset_payload: got addr=%h wdata=%h wstrb=%h want 0", bus.m_addr, bus.m_wdata, bus.m_wstrb);
        end
        n_checks++;
        if (bus.rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_rdata: got %h want 0", bus.rdata);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_fetch();
        bus.i_req = 1'b1; bus.i_addr = 32'h100; resp_data = 32'hDEAD_BEEF;
        #1;
        n_checks++;
        if (bus.m_req !== 1'b0) begin
            n_fail++; $display("FAIL fetch_c0_mreq: got %b want 0", bus.m_req);
        end
        tick();
        n_checks++;
        if ({bus.m_req, bus.i_gnt, bus.d_gnt} !== 3'b110 || bus.m_addr !== 32'h100 || bus.m_wstrb !== 4'h0) begin
            n_fail++;
            $display("FAIL fetch_c1_grant: got req/ig/dg=%b addr=%h wstrb=%h want 110 100 0", {bus.m_req, bus.i_gnt, bus.d_gnt}, bus.m_addr, bus.m_wstrb);
        end
        tick();
        bus.i_req = 1'b0;
        #1;
        n_checks++;
        if ({bus.i_rvalid, bus.d_rvalid, bus.m_req} !== 3'b100 || bus.rdata !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL fetch_c2_rvalid: got iv/dv/req=%b rdata=%h want 100 deadbeef", {bus.i_rvalid, bus.d_rvalid, bus.m_req}, bus.rdata);
        end
        $display("txn fetch addr=%h rdata=%h", 32'h100, bus.rdata);
        tick();
        n_checks++;
        if ({bus.m_req, bus.i_rvalid, bus.d_gnt, bus.d_rvalid} !== 4'b0) begin
            n_fail++;
            $display("FAIL fetch_c3_idle: got %b want 0000", {bus.m_req, bus.i_rvalid, bus.d_gnt, bus.d_rvalid});
        end
    endtask

    task automatic test_simultaneous();
        bus.i_req = 1'b1; bus.i_addr = 32'h180;
        bus.d_req = 1'b1; bus.d_addr = 32'h200; bus.d_wdata = 32'h1122_3344; bus.d_wstrb = 4'b0011;
        tick();
        n_checks++;
        if ({bus.m_req, bus.d_gnt, bus.i_gnt} !== 3'b110 || bus.m_addr !== 32'h200 || bus.m_wstrb !== 4'b0011 || bus.m_wdata !== 32'h1122_3344) begin
            n_fail++;
            $display("FAIL simul_data_first: got req/dg/ig=%b addr=%h wstrb=%b wdata=%h want 110 200 0011 11223344", {bus.m_req, bus.d_gnt, bus.i_gnt}, bus.m_addr, bus.m_wstrb, bus.m_wdata);
        end
        tick();
        bus.d_req = 1'b0; resp_data = 32'h5A5A_5A5A;
        #1;
        n_checks++;
        if ({bus.d_rvalid, bus.i_rvalid} !== 2'b10 || bus.rdata !== 32'h5A5A_5A5A) begin
            n_fail++;
            $display("FAIL simul_d_rvalid: got dv/iv=%b rdata=%h want 10 5a5a5a5a", {bus.d_rvalid, bus.i_rvalid}, bus.rdata);
        end
        $display("txn store addr=%h wstrb=0011 ack", 32'h200);
        tick();
        n_checks++;
        if ({bus.m_req, bus.i_gnt, bus.d_gnt} !== 3'b110 || bus.m_addr !== 32'h180 || bus.m_wstrb !== 4'h0) begin
            n_fail++;
            $display("FAIL simul_fetch_b2b: got req/ig/dg=%b addr=%h wstrb=%h want 110 180 0", {bus.m_req, bus.i_gnt, bus.d_gnt}, bus.m_addr, bus.m_wstrb);
        end
        tick();
        bus.i_req = 1'b0;
        #1;
        n_checks++;
        if ({bus.i_rvalid, bus.d_rvalid} !== 2'b10) begin
            n_fail++;
            $display("FAIL simul_i_rvalid: got iv/dv=%b want 10", {bus.i_rvalid, bus.d_rvalid});
        end
        $display("txn fetch addr=%h rdata=%h", 32'h180, bus.rdata);
        tick();
    endtask

    task automatic test_starvation();
        logic exp_is_d [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        int n_g = 0;
        bus.i_req = 1'b1; bus.i_addr = 32'h1000;
        bus.d_req = 1'b1; bus.d_addr = 32'h2000; bus.d_wdata = '0; bus.d_wstrb = 4'h0;
        for (int c = 0; c < 40 && n_g < 10; c++) begin
            tick();
            if (bus.i_gnt || bus.d_gnt) begin
                n_checks++;
                if (bus.d_gnt !== exp_is_d[n_g] || bus.i_gnt !== !exp_is_d[n_g]) begin
                    n_fail++;
                    $display("FAIL starve_grant%0d: got dg/ig=%b%b want %b%b", n_g, bus.d_gnt, bus.i_gnt, exp_is_d[n_g], !exp_is_d[n_g]);
                end
                $display("txn grant#%0d %s addr=%h", n_g, bus.d_gnt ? "data" : "fetch", bus.m_addr);
                n_g++;
            end
        end
        n_checks++;
        if (n_g != 10) begin
            n_fail++;
            $display("FAIL starve_count: got %0d grants want 10", n_g);
        end
        tick();
        bus.i_req = 1'b0; bus.d_req = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_gnt_wait();
        gnt_en = 1'b0;
        bus.d_req = 1'b1; bus.d_addr = 32'h300; bus.d_wdata = 32'hCAFE_F00D; bus.d_wstrb = 4'hF;
        for (int c = 0; c < 5; c++) begin
            tick();
            n_checks++;
            if (bus.m_req !== 1'b1 || bus.m_addr !== 32'h300 || bus.m_wdata !== 32'hCAFE_F00D || bus.m_wstrb !== 4'hF
                || {bus.d_gnt, bus.i_gnt} !== 2'b00) begin
                n_fail++;
                $display("FAIL wait_stable%0d: got req=%b addr=%h wdata=%h wstrb=%h dg/ig=%b%b want 1 300 cafef00d f 00",
                         c, bus.m_req, bus.m_addr, bus.m_wdata, bus.m_wstrb, bus.d_gnt, bus.i_gnt);
            end
        end
        tick();
        gnt_en = 1'b1;
        #1;
        n_checks++;
        if (bus.d_gnt !== 1'b1) begin
            n_fail++; $display("FAIL wait_gnt: got %b want 1", bus.d_gnt);
        end
        tick();
        bus.d_req = 1'b0;
        #1;
        n_checks++;
        if (bus.d_rvalid !== 1'b1) begin
            n_fail++; $display("FAIL wait_rvalid: got %b want 1", bus.d_rvalid);
        end
        $display("txn store addr=%h wdata=%h after stall", 32'h300, 32'hCAFE_F00D);
        tick();
    endtask

    task automatic test_reset_mid();
        auto_en = 1'b0;
        bus.i_req = 1'b1; bus.i_addr = 32'h400;
        tick();
        n_checks++;
        if (bus.i_gnt !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_gnt: got %b want 1", bus.i_gnt);
        end
        tick();
        bus.i_req = 1'b0;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.m_req, bus.i_gnt, bus.d_gnt, bus.i_rvalid, bus.d_rvalid} !== 5'b0
            || {bus.m_addr, bus.m_wdata, bus.m_wstrb} !== '0 || bus.rdata !== '0) begin
            n_fail++;
            $display("FAIL rstmid_zero: got ctrl=%b addr=%h wstrb=%h rdata=%h want all 0",
                     {bus.m_req, bus.i_gnt, bus.d_gnt, bus.i_rvalid, bus.d_rvalid}, bus.m_addr, bus.m_wstrb, bus.rdata);
        end
        tick();
        rst_n = 1'b1; resp_data = 32'h1234_5678; force_rv = 1'b1;
        #1;
        n_checks++;
        if ({bus.i_rvalid, bus.d_rvalid} !== 2'b00 || bus.rdata !== '0) begin
            n_fail++;
            $display("FAIL rstmid_stray: got iv/dv=%b rdata=%h want 00 0", {bus.i_rvalid, bus.d_rvalid}, bus.rdata);
        end
        tick();
        force_rv = 1'b0; auto_en = 1'b1;
        bus.d_req = 1'b1; bus.d_addr = 32'h500; bus.d_wstrb = 4'h0; resp_data = 32'h0BAD_CAFE;
        #1;
        n_checks++;
        if (bus.m_req !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_idle: got m_req=%b want 0", bus.m_req);
        end
        tick();
        n_checks++;
        if ({bus.m_req, bus.d_gnt} !== 2'b11 || bus.m_addr !== 32'h500) begin
            n_fail++;
            $display("FAIL rstmid_next_gnt: got req/dg=%b addr=%h want 11 500", {bus.m_req, bus.d_gnt}, bus.m_addr);
        end
        tick();
        bus.d_req = 1'b0;
        #1;
        n_checks++;
        if (bus.d_rvalid !== 1'b1 || bus.rdata !== 32'h0BAD_CAFE) begin
            n_fail++;
            $display("FAIL rstmid_next_rv: got dv=%b rdata=%h want 1 0badcafe", bus.d_rvalid, bus.rdata);
        end
        $display("txn load addr=%h rdata=%h after reset", 32'h500, bus.rdata);
        tick();
    endtask

    task automatic test_spurious();
        force_rv = 1'b1; resp_data = 32'hFFFF_FFFF;
        #1;
        n_checks++;
        if ({bus.i_rvalid, bus.d_rvalid} !== 2'b00 || bus.rdata !== '0) begin
            n_fail++;
            $display("FAIL spur_rvalid: got iv/dv=%b rdata=%h want 00 0", {bus.i_rvalid, bus.d_rvalid}, bus.rdata);
        end
        tick();
        force_rv = 1'b0;
        bus.i_req = 1'b1; bus.i_addr = 32'h600; resp_data = 32'h6666_6666;
        #1;
        n_checks++;
        if (bus.m_req !== 1'b0) begin
            n_fail++; $display("FAIL spur_state: got m_req=%b want 0", bus.m_req);
        end
        tick();
        n_checks++;
        if ({bus.m_req, bus.i_gnt} !== 2'b11 || bus.m_addr !== 32'h600) begin
            n_fail++;
            $display("FAIL spur_next_gnt: got req/ig=%b addr=%h want 11 600", {bus.m_req, bus.i_gnt}, bus.m_addr);
        end
        tick();
        bus.i_req = 1'b0;
        #1;
        n_checks++;
        if (bus.i_rvalid !== 1'b1 || bus.rdata !== 32'h6666_6666) begin
            n_fail++;
            $display("FAIL spur_next_rv: got iv=%b rdata=%h want 1 66666666", bus.i_rvalid, bus.rdata);
        end
        $display("txn fetch addr=%h rdata=%h", 32'h600, bus.rdata);
        tick();
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_simultaneous();
        test_starvation();
        test_gnt_wait();
        test_reset_mid();
        test_spurious();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no completion want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
